timer_countdown: RTL and testbench
==================================

// Module: timer_countdown
// PURPOSE
//  Microwave cook timer; sits directly upstream of the magnetron control and produces its timer_done input.
//  Keypad digits shift into a 4-digit BCD MM:SS register while the magnetron is off.
//  While mag_on=1 the register counts down once per second.
//  timer_done is high whenever the count is 00:00; it feeds the magnetron control and stops heating.
// PARAMETERS
//  CLK_PER_SEC  100  clk cycles per one-second tick; must be >=2; prescaler width = $clog2(CLK_PER_SEC)
// PORTS
//  clk         in   1  single system clock, rising edge
//  resetn      in   1  asynchronous, active-low reset
//  clearn      in   1  synchronous, active-low clear of count and prescaler
//  key_valid   in   1  one-cycle strobe: key_digit holds a new keypad digit
//  key_digit   in   4  BCD digit 0-9; values 10-15 are ignored
//  mag_on      in   1  magnetron on; from magnetron control; enables counting
//  min_tens    out  4  BCD minutes tens
//  min_ones    out  4  BCD minutes ones
//  sec_tens    out  4  BCD seconds tens
//  sec_ones    out  4  BCD seconds ones
//  timer_done  out  1  high when all four digits are 0
// BEHAVIOUR
//  Reset (resetn=0, async): all digits 0, prescaler 0, state IDLE, timer_done=1.
//  FSM states and transitions:
//   IDLE -> LOAD on first valid key.
//   LOAD -> RUN when mag_on=1 and count!=0.
//   RUN -> PAUSE when mag_on=0 and count!=0.
//   PAUSE -> RUN when mag_on=1.
//   RUN -> DONE when count reaches 0.
//   DONE -> LOAD on a valid key.
//   Any state -> IDLE on clearn=0.
//  Priority per cycle: clearn > key entry > tick.
//  Key entry: accepted only when mag_on=0, key_valid=1 and key_digit<=9; one-cycle latency.
//   Shift: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
//   The old min_tens is discarded. An accepted key also zeroes the prescaler.
//   sec_tens may hold 6-9 after entry (e.g. 0:99); it is counted down as typed, not normalised.
//  Prescaler:
//   Increments only when mag_on=1 and count!=0.
//   Holds its value while mag_on=0 (pause and resume keep the partial second).
//   At CLK_PER_SEC-1 it wraps to 0 and issues a tick in the same cycle.
//  Tick: BCD decrement with borrow chain.
//   sec_ones 0->9 borrows from sec_tens.
//   sec_tens 0->5 borrows from min_ones.
//   min_ones 0->9 borrows from min_tens.
//   The count never goes below 00:00.
//  timer_done: registered; equals (count==0) as of the same clock edge that updates the count.
//   It rises in the cycle 00:01 becomes 00:00 and falls in the cycle a nonzero digit is entered.
//   Latency from tick to timer_done: 0 extra cycles.
//  Boundary conditions:
//   key_valid while mag_on=1: ignored.
//   mag_on=1 with count 0: no counting; timer_done stays 1.
//   clearn=0 while running: count goes to 0, so timer_done=1 next edge.
//   resetn mid-count: immediate return to reset values.
// STRUCTURE
//  Include file timer_defs.vh holds:
//   FSM state encodings: IDLE, LOAD, RUN, PAUSE, DONE.
//   BCD constants: BCD_MAX=9, SEC_TENS_WRAP=5.
//  One sub-module, bcd_down_digit: parameter WRAP; ports clk, resetn, clr, load, load_val, dec_in, q, borrow_out.
//   Four instances: WRAP=9, 5, 9, 9.
//   borrow_out = dec_in & (q==0).
//  Top level holds the FSM, prescaler, key shift muxing and the zero detect.
// TESTING
//  All scenarios use CLK_PER_SEC=4.
//  1. Reset: pulse resetn low mid-cycle -> digits 0 immediately, timer_done=1.
//  2. Entry: keys 1,3,0 with mag_on=0 -> 01:30, timer_done=0; key 12 -> no change.
//  3. Countdown: load 00:02, mag_on=1 -> 00:01 after 4 clks, 00:00 after 8 clks; timer_done=1 at clk 8; stays 00:00.
//  4. Borrow: load 10:00, one tick -> 09:59; load 01:00, one tick -> 00:59.
//  5. Pause: load 00:05, mag_on=1 for 2 clks, then 0 for 10 clks, then 1 -> first tick 2 clks after resume; key_valid during mag_on=1 ignored.
//  6. Clear: clearn=0 at 03:17 while running -> 00:00, timer_done=1 next edge, state IDLE; simultaneous key ignored.

Source files
------------

// File: rtl/timer_countdown_pkg.sv
// Shared definitions for the microwave cook timer: controller states,
// BCD digit limits and a small digit-validity helper.
package timer_countdown_pkg;

  // Controller states. The state is kept for sequencing and observability;
  // the datapath enables are derived directly from the inputs and the count.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Largest legal BCD digit; also the wrap value of every "ones" digit.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Seconds-tens wraps to 5 on a borrow so that x:00 becomes (x-1):59.
  localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

  // True for the keypad codes 0-9; codes 10-15 are not digits.
  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/timer_countdown_bcd_down_digit.sv
// One BCD down-counting digit of the MM:SS register. It can be cleared,
// parallel-loaded (used for the keypad shift) or decremented by one. On a
// decrement from 0 it wraps to WRAP and reports a borrow to the next digit.
module bcd_down_digit
  import timer_countdown_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_in,
  output logic [3:0] q,
  output logic       borrow_out
);

  // Digit register: clear beats load, load beats decrement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (dec_in) begin
      if (q == 4'd0) begin
        q <= WRAP;
      end else begin
        q <= q - 4'd1;
      end
    end
  end

  // A decrement that finds this digit at zero must borrow from the next one.
  assign borrow_out = dec_in & (q == 4'd0);

endmodule

// File: rtl/timer_countdown.sv
// Microwave cook timer. Keypad digits shift into a four-digit BCD MM:SS
// register while the magnetron is off; while it is on the register counts
// down once per second. timer_done tells the magnetron control to stop.
module timer_countdown
  import timer_countdown_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done
);

  localparam int unsigned PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  state_t        state;
  logic [PW-1:0] presc;

  logic key_accept;
  logic key_load;
  logic count_zero;
  logic count_nz;
  logic last_second;
  logic tick;
  logic next_zero;
  logic digit_clr;

  logic borrow_sec_ones;
  logic borrow_sec_tens;
  logic borrow_min_ones;
  logic borrow_min_tens;

  // A key is only taken with the magnetron off and a real digit on the bus;
  // the clear input overrides it.
  assign key_accept = ~mag_on & key_valid & is_bcd_digit(key_digit);
  assign key_load   = clearn & key_accept;

  assign count_zero  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
  assign count_nz    = ~count_zero;
  assign last_second = ({min_tens, min_ones, sec_tens} == 12'h000) &&
                       (sec_ones == 4'd1);

  // The one-second tick fires on the wrap of the prescaler, only while
  // heating with time left, and never in a cycle that is being cleared.
  assign tick = clearn & mag_on & count_nz & (presc == PRESC_LAST);

  // The tick gating already stops the count at 00:00; the top borrow is a
  // guard that forces zero instead of wrapping to 99:59 should it ever occur.
  assign digit_clr = ~clearn | borrow_min_tens;

  // Zero-ness of the count as it will be after this clock edge, so that
  // timer_done can be registered without an extra cycle of latency.
  always_comb begin
    next_zero = count_zero;
    if (!clearn) begin
      next_zero = 1'b1;
    end else if (key_accept) begin
      next_zero = ({min_ones, sec_tens, sec_ones, key_digit} == 16'h0000);
    end else if (tick) begin
      next_zero = last_second;
    end
  end

  bcd_down_digit #(.WRAP(BCD_MAX)) u_sec_ones (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (digit_clr),
    .load       (key_load),
    .load_val   (key_digit),
    .dec_in     (tick),
    .q          (sec_ones),
    .borrow_out (borrow_sec_ones)
  );

  bcd_down_digit #(.WRAP(SEC_TENS_WRAP)) u_sec_tens (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (digit_clr),
    .load       (key_load),
    .load_val   (sec_ones),
    .dec_in     (borrow_sec_ones),
    .q          (sec_tens),
    .borrow_out (borrow_sec_tens)
  );

  bcd_down_digit #(.WRAP(BCD_MAX)) u_min_ones (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (digit_clr),
    .load       (key_load),
    .load_val   (sec_tens),
    .dec_in     (borrow_sec_tens),
    .q          (min_ones),
    .borrow_out (borrow_min_ones)
  );

  bcd_down_digit #(.WRAP(BCD_MAX)) u_min_tens (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (digit_clr),
    .load       (key_load),
    .load_val   (min_ones),
    .dec_in     (borrow_min_ones),
    .q          (min_tens),
    .borrow_out (borrow_min_tens)
  );

  // Prescaler: restarts on clear or a new key, holds while paused so a
  // resume keeps the partial second, and wraps in the cycle it ticks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
    end else if (!clearn || key_accept) begin
      presc <= '0;
    end else if (mag_on && count_nz) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Registered done flag, updated on the same edge as the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_done <= 1'b1;
    end else begin
      timer_done <= next_zero;
    end
  end

  // Controller sequencing: entry, running, paused and finished phases.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else if (!clearn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) state <= LOAD;
        end
        LOAD: begin
          if (mag_on && count_nz) state <= RUN;
        end
        RUN: begin
          if (next_zero) begin
            state <= DONE;
          end else if (!mag_on) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (mag_on) state <= RUN;
        end
        DONE: begin
          if (key_load) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for the cook timer with a one-second tick of four clocks. A
// seconds-level model tracks the typed MM:SS value and is compared with the
// DUT every cycle; directed scenarios add hand-computed expectations.
module tb_timer_countdown;

  localparam int unsigned CPS = 4;

  logic       clk;
  logic       resetn;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;

  int checks   = 0;
  int failures = 0;

  // Model state: the display as a four-digit decimal number MMSS, plus the
  // number of clocks spent in the current second.
  int m_val = 0;
  int m_ps  = 0;

  timer_countdown #(.CLK_PER_SEC(CPS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .mag_on     (mag_on),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model update: typed digits shift in decimally; one second is removed
  // per CPS heating clocks, minutes rolling into 59 seconds.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_val = 0;
      m_ps  = 0;
    end else if (!clearn) begin
      m_val = 0;
      m_ps  = 0;
    end else if (!mag_on && key_valid && key_digit <= 4'd9) begin
      m_val = (m_val * 10 + int'(key_digit)) % 10000;
      m_ps  = 0;
    end else if (mag_on && m_val != 0) begin
      if (m_ps == CPS - 1) begin
        m_ps = 0;
        if (m_val % 100 != 0) m_val = m_val - 1;
        else                  m_val = m_val - 100 + 59;
      end else begin
        m_ps = m_ps + 1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== to_bcd(m_val) ||
          timer_done !== (m_val == 0)) begin
        failures++;
        $display("[TB] FAIL cycle_model at %0t: got %h done=%b, expected %h done=%b",
                 $time, {min_tens, min_ones, sec_tens, sec_ones}, timer_done,
                 to_bcd(m_val), (m_val == 0));
      end
    end
  end

  // Hand-computed expectation, checked against both the DUT and the model.
  task automatic check_output(input string name, input logic [15:0] exp_bcd,
                              input logic exp_done);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    if (got !== exp_bcd || timer_done !== exp_done) begin
      failures++;
      $display("[TB] FAIL %s: got %h done=%b, expected %h done=%b",
               name, got, timer_done, exp_bcd, exp_done);
    end
    checks++;
    if (to_bcd(m_val) !== exp_bcd) begin
      failures++;
      $display("[TB] FAIL %s_model: model %h, expected %h", name, to_bcd(m_val), exp_bcd);
    end
  endtask

  // Drive one input pattern for a number of clocks, then drop the key strobe.
  task automatic apply_stimulus(input logic mag, input logic kv, input logic [3:0] kd,
                                input logic cl, input int cycles);
    mag_on    = mag;
    key_valid = kv;
    key_digit = kd;
    clearn    = cl;
    repeat (cycles) @(negedge clk);
    key_valid = 1'b0;
    clearn    = 1'b1;
  endtask

  task automatic press_key(input logic [3:0] d);
    apply_stimulus(1'b0, 1'b1, d, 1'b1, 1);
  endtask

  task automatic clear_timer();
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn    = 1'b0;
    clearn    = 1'b1;
    key_valid = 1'b0;
    key_digit = 4'd0;
    mag_on    = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_output("reset_release", 16'h0000, 1'b1);

    // Keypad entry, then an out-of-range code that must be ignored.
    press_key(4'd1);
    press_key(4'd3);
    press_key(4'd0);
    check_output("entry_0130", 16'h0130, 1'b0);
    press_key(4'd12);
    check_output("entry_bad_key", 16'h0130, 1'b0);

    // Countdown from 00:02 with four clocks per second.
    clear_timer();
    press_key(4'd0);
    press_key(4'd2);
    check_output("load_0002", 16'h0002, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 3);
    check_output("count_clk3", 16'h0002, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 1);
    check_output("count_clk4", 16'h0001, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 4);
    check_output("count_clk8", 16'h0000, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 4);
    check_output("count_hold_zero", 16'h0000, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);

    // Borrow chains.
    clear_timer();
    press_key(4'd1); press_key(4'd0); press_key(4'd0); press_key(4'd0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 4);
    check_output("borrow_1000", 16'h0959, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);
    clear_timer();
    press_key(4'd1); press_key(4'd0); press_key(4'd0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 4);
    check_output("borrow_0100", 16'h0059, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);

    // Seconds typed above 59 count down as typed.
    clear_timer();
    press_key(4'd9); press_key(4'd9);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 4);
    check_output("unnormalised_0099", 16'h0098, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);

    // Pause keeps the partial second; keys while heating are ignored.
    clear_timer();
    press_key(4'd5);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 2);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 10);
    check_output("paused", 16'h0005, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'd7, 1'b1, 1);
    check_output("resume_clk1_key_ignored", 16'h0005, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 1);
    check_output("resume_clk2_tick", 16'h0004, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);

    // Heating with a zero count must not advance the prescaler.
    clear_timer();
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 5);
    check_output("mag_on_zero", 16'h0000, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);
    press_key(4'd2);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 3);
    check_output("fresh_prescaler_clk3", 16'h0002, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 1);
    check_output("fresh_prescaler_clk4", 16'h0001, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);

    // Clear while running, with a simultaneous key.
    clear_timer();
    press_key(4'd3); press_key(4'd1); press_key(4'd7);
    check_output("load_0317", 16'h0317, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 3);
    apply_stimulus(1'b1, 1'b1, 4'd4, 1'b0, 1);
    check_output("clear_running", 16'h0000, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);
    press_key(4'd3); press_key(4'd1); press_key(4'd7);
    apply_stimulus(1'b0, 1'b1, 4'd4, 1'b0, 1);
    check_output("clear_beats_key", 16'h0000, 1'b1);
    press_key(4'd0);
    check_output("zero_key_keeps_done", 16'h0000, 1'b1);

    // Asynchronous reset in the middle of a count.
    press_key(4'd4); press_key(4'd5);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 2);
    @(posedge clk);
    #2 resetn = 1'b0;
    mag_on = 1'b0;
    #1 check_output("async_reset", 16'h0000, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    press_key(4'd6);
    check_output("after_reset_key", 16'h0006, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
